// File: rtl/unpack_1to8.sv
// Purpose : unpack 32-bit words into a stream of eight 4-bit nibbles.
// Latency : a word accepted into an empty block shows its first nibble right after the accepting edge.
// Backpr. : a one-word hold register takes a second word, and inrdy drops while that register is full.
//
// Ports:
//   clk, n_rst      - clock; reset is synchronous and active-low
//   flush           - synchronous clear of all data state (the ovf/udf sticky flags survive it)
//   inen, in, inrdy - word input; a word is accepted when inen && inrdy
//   outen, out      - nibble output; a nibble is consumed when outen && outvld
//   outvld, empty   - a nibble is available / nothing is held anywhere in the block
//   cnt             - nibbles left in the shift register (0..8)
//   ovf, udf        - sticky: word offered while full / nibble taken while invalid
module unpack_1to8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        flush,
  input  logic        inen,
  input  logic [31:0] in,
  output logic        inrdy,
  input  logic        outen,
  output logic [3:0]  out,
  output logic        outvld,
  output logic        empty,
  output logic [3:0]  cnt,
  output logic        ovf,
  output logic        udf
);

  logic [31:0] sr_q, sr_d;
  logic [31:0] hr_q, hr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hv_q, hv_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  logic        consume;
  logic        accept;
  logic        last_slot;
  logic [31:0] sr_shifted;

  // All outputs are decoded from registered state only.
  assign inrdy  = !hv_q;
  assign outvld = (cnt_q != 4'd0);
  assign empty  = (cnt_q == 4'd0) && !hv_q;
  assign cnt    = cnt_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

  always_comb begin
    out = 4'h0;
    if (cnt_q != 4'd0) begin
      out = MSB_FIRST ? sr_q[31:28] : sr_q[3:0];
    end
  end

  assign consume = outen && outvld;
  assign accept  = inen && inrdy;

  // The shift register may be reloaded on this edge when it is already empty,
  // or when its final nibble is consumed on this same edge. Reloading then
  // avoids a bubble cycle between consecutive words.
  assign last_slot = (cnt_q == 4'd0) || ((cnt_q == 4'd1) && consume);

  // Shift toward the output end; the vacated nibble is filled with zero.
  assign sr_shifted = MSB_FIRST ? {sr_q[27:0], 4'h0} : {4'h0, sr_q[31:4]};

  always_comb begin
    sr_d  = sr_q;
    hr_d  = hr_q;
    cnt_d = cnt_q;
    hv_d  = hv_q;
    ovf_d = ovf_q;
    udf_d = udf_q;

    if (flush) begin
      // Simultaneous inen/outen are ignored, so no sticky flag is set here.
      sr_d  = 32'h0;
      hr_d  = 32'h0;
      cnt_d = 4'd0;
      hv_d  = 1'b0;
    end else begin
      if (inen && !inrdy) begin
        ovf_d = 1'b1;
      end
      if (outen && !outvld) begin
        udf_d = 1'b1;
      end

      if (consume) begin
        sr_d  = sr_shifted;
        cnt_d = cnt_q - 4'd1;
      end

      if (last_slot) begin
        // A held word always takes priority over the input. The two cannot
        // both be pending, because inrdy is low whenever hv_q is set.
        if (hv_q) begin
          sr_d  = hr_q;
          cnt_d = 4'd8;
          hv_d  = 1'b0;
        end else if (accept) begin
          sr_d  = in;
          cnt_d = 4'd8;
        end
      end else if (accept) begin
        hr_d = in;
        hv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sr_q  <= 32'h0;
      hr_q  <= 32'h0;
      cnt_q <= 4'd0;
      hv_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      hr_q  <= hr_d;
      cnt_q <= cnt_d;
      hv_q  <= hv_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

endmodule

// File: tb/tb_unpack_1to8.sv
// Bench for unpack_1to8: drives one MSB-first and one LSB-first instance with the same stimulus.
// A word-level reference model tracks the current word, the nibbles left, the held word and the flags.
// Every falling edge compares both instances against the model, and directed steps add literal checks.
module tb_unpack_1to8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        flush = 1'b0;
  logic        inen = 1'b0;
  logic [31:0] in_w = 32'h0;
  logic        outen = 1'b0;

  logic       inrdy_m, outvld_m, empty_m, ovf_m, udf_m;
  logic [3:0] out_m, cnt_m;
  logic       inrdy_l, outvld_l, empty_l, ovf_l, udf_l;
  logic [3:0] out_l, cnt_l;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  unpack_1to8 #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .n_rst(n_rst), .flush(flush), .inen(inen), .in(in_w),
    .inrdy(inrdy_m), .outen(outen), .out(out_m), .outvld(outvld_m),
    .empty(empty_m), .cnt(cnt_m), .ovf(ovf_m), .udf(udf_m)
  );

  unpack_1to8 #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .n_rst(n_rst), .flush(flush), .inen(inen), .in(in_w),
    .inrdy(inrdy_l), .outen(outen), .out(out_l), .outvld(outvld_l),
    .empty(empty_l), .cnt(cnt_l), .ovf(ovf_l), .udf(udf_l)
  );

  // ---------------- reference model (word level) ----------------
  logic [31:0] m_word = 32'h0;
  logic [31:0] m_hold = 32'h0;
  int          m_cnt  = 0;
  bit          m_hv   = 1'b0;
  bit          m_ovf  = 1'b0;
  bit          m_udf  = 1'b0;

  always @(posedge clk) begin : model
    int left;
    if (!n_rst) begin
      m_word = 32'h0; m_hold = 32'h0; m_cnt = 0; m_hv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (flush) begin
      m_word = 32'h0; m_hold = 32'h0; m_cnt = 0; m_hv = 1'b0;
    end else begin
      if (outen && m_cnt == 0) m_udf = 1'b1;
      if (inen && m_hv) m_ovf = 1'b1;
      // Number of nibbles left once this edge's consume has happened.
      left = m_cnt - ((outen && m_cnt != 0) ? 1 : 0);
      if (left == 0) begin
        if (m_hv) begin
          m_word = m_hold; m_cnt = 8; m_hv = 1'b0;
        end else if (inen) begin
          m_word = in_w; m_cnt = 8;
        end else begin
          m_cnt = 0;
        end
      end else begin
        m_cnt = left;
        if (inen && !m_hv) begin
          m_hold = in_w; m_hv = 1'b1;
        end
      end
    end
  end

  // Nibble number (8 - nibbles left) of the current word, in the given order.
  function automatic logic [3:0] exp_nib(bit msb);
    int n;
    if (m_cnt == 0) return 4'h0;
    n = 8 - m_cnt;
    return msb ? m_word[31 - 4*n -: 4] : m_word[4*n +: 4];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("m.out",    {28'h0, out_m},    {28'h0, exp_nib(1'b1)});
      check("l.out",    {28'h0, out_l},    {28'h0, exp_nib(1'b0)});
      check("m.cnt",    {28'h0, cnt_m},    m_cnt);
      check("l.cnt",    {28'h0, cnt_l},    m_cnt);
      check("m.outvld", {31'h0, outvld_m}, {31'h0, m_cnt != 0});
      check("l.outvld", {31'h0, outvld_l}, {31'h0, m_cnt != 0});
      check("m.inrdy",  {31'h0, inrdy_m},  {31'h0, !m_hv});
      check("l.inrdy",  {31'h0, inrdy_l},  {31'h0, !m_hv});
      check("m.empty",  {31'h0, empty_m},  {31'h0, (m_cnt == 0) && !m_hv});
      check("l.empty",  {31'h0, empty_l},  {31'h0, (m_cnt == 0) && !m_hv});
      check("m.ovf",    {31'h0, ovf_m},    {31'h0, m_ovf});
      check("l.ovf",    {31'h0, ovf_l},    {31'h0, m_ovf});
      check("m.udf",    {31'h0, udf_m},    {31'h0, m_udf});
      check("l.udf",    {31'h0, udf_l},    {31'h0, m_udf});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset with other inputs active, which reset must override.
    n_rst = 1'b0; flush = 1'b1; inen = 1'b1; outen = 1'b1; in_w = 32'hFFFF_FFFF;
    tick();
    n_rst = 1'b1; flush = 1'b0; inen = 1'b0; outen = 1'b0;
    chk_en = 1'b1;
    check("rst.out",    {28'h0, out_m},    32'h0);
    check("rst.outvld", {31'h0, outvld_m}, 32'h0);
    check("rst.inrdy",  {31'h0, inrdy_m},  32'h1);
    check("rst.empty",  {31'h0, empty_m},  32'h1);
    check("rst.cnt",    {28'h0, cnt_m},    32'h0);
    check("rst.ovf",    {31'h0, ovf_m},    32'h0);
    check("rst.udf",    {31'h0, udf_m},    32'h0);

    // Basic unpack of one word in both nibble orders.
    inen = 1'b1; in_w = 32'h1234_5678;
    tick();
    inen = 1'b0; outen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("seq.m_out", {28'h0, out_m}, i + 1);
      check("seq.l_out", {28'h0, out_l}, 8 - i);
      check("seq.cnt",   {28'h0, cnt_m}, 8 - i);
      tick();
    end
    outen = 1'b0;
    check("seq.outvld_end", {31'h0, outvld_m}, 32'h0);
    check("seq.empty_end",  {31'h0, empty_m},  32'h1);

    // Back-to-back words with the second one held while the first unpacks.
    inen = 1'b1; in_w = 32'hAAAA_AAAA;
    tick();
    inen = 1'b0; outen = 1'b1;
    for (int c = 0; c < 16; c++) begin
      check("b2b.outvld", {31'h0, outvld_m}, 32'h1);
      check("b2b.m_out",  {28'h0, out_m}, (c < 8) ? 32'hA : 32'h5);
      check("b2b.l_out",  {28'h0, out_l}, (c < 8) ? 32'hA : 32'h5);
      if (c == 2) begin
        check("b2b.cnt_at_load", {28'h0, cnt_m}, 32'd6);
        inen = 1'b1; in_w = 32'h5555_5555;
      end
      tick();
      inen = 1'b0;
      if (c == 2) check("b2b.inrdy", {31'h0, inrdy_m}, 32'h0);
    end
    outen = 1'b0;
    check("b2b.empty_end", {31'h0, empty_m}, 32'h1);

    // An overflow drops the offered word; ovf survives flush and clears on reset.
    inen = 1'b1; in_w = 32'h1357_9BDF;
    tick();
    in_w = 32'h2468_ACE0;
    tick();
    check("ovf.before", {31'h0, ovf_m}, 32'h0);
    in_w = 32'hDEAD_BEEF;
    tick();
    inen = 1'b0;
    check("ovf.set",   {31'h0, ovf_m},   32'h1);
    check("ovf.inrdy", {31'h0, inrdy_m}, 32'h0);
    outen = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) check("ovf.first_m", {28'h0, out_m}, 32'h1);
      if (c == 8) check("ovf.held_m",  {28'h0, out_m}, 32'h2);
      if (c == 8) check("ovf.held_l",  {28'h0, out_l}, 32'h0);
      tick();
    end
    outen = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovf.after_flush", {31'h0, ovf_m}, 32'h1);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("ovf.after_rst", {31'h0, ovf_m}, 32'h0);

    // Underflow, then a load at cnt=1 together with the final consume.
    outen = 1'b1;
    tick();
    outen = 1'b0;
    check("udf.set", {31'h0, udf_m}, 32'h1);
    check("udf.cnt", {28'h0, cnt_m}, 32'h0);
    inen = 1'b1; in_w = 32'h9ABC_DEF0;
    tick();
    inen = 1'b0; outen = 1'b1;
    repeat (7) tick();
    check("cnt1.cnt", {28'h0, cnt_m}, 32'd1);
    inen = 1'b1; in_w = 32'h4321_8765;
    tick();
    inen = 1'b0; outen = 1'b0;
    check("cnt1.cnt_after", {28'h0, cnt_m},   32'd8);
    check("cnt1.m_out",     {28'h0, out_m},   32'h4);
    check("cnt1.l_out",     {28'h0, out_l},   32'h5);
    check("cnt1.inrdy",     {31'h0, inrdy_m}, 32'h1);

    // Flush mid-unpack with inen/outen active: data cleared, flags unchanged.
    inen = 1'b1; in_w = 32'h1111_2222;
    tick();
    inen = 1'b0; outen = 1'b1;
    repeat (3) tick();
    check("fl.cnt5",  {28'h0, cnt_m},   32'd5);
    check("fl.inrdy", {31'h0, inrdy_m}, 32'h0);
    flush = 1'b1; inen = 1'b1; in_w = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; inen = 1'b0; outen = 1'b0;
    check("fl.cnt",    {28'h0, cnt_m},    32'h0);
    check("fl.empty",  {31'h0, empty_m},  32'h1);
    check("fl.inrdy2", {31'h0, inrdy_m},  32'h1);
    check("fl.ovf",    {31'h0, ovf_m},    32'h0);
    check("fl.udf",    {31'h0, udf_m},    32'h1);
    check("fl.outvld", {31'h0, outvld_m}, 32'h0);

    // Same point, with ovf also set, then a reset clears everything.
    inen = 1'b1; in_w = 32'h1111_2222;
    tick();
    in_w = 32'h3333_4444;
    tick();
    inen = 1'b0; outen = 1'b1;
    repeat (3) tick();
    check("rs.cnt5", {28'h0, cnt_m}, 32'd5);
    inen = 1'b1; in_w = 32'h7777_7777;
    tick();
    check("rs.ovf_set", {31'h0, ovf_m}, 32'h1);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1; inen = 1'b0; outen = 1'b0;
    check("rs.cnt",   {28'h0, cnt_m},   32'h0);
    check("rs.empty", {31'h0, empty_m}, 32'h1);
    check("rs.inrdy", {31'h0, inrdy_m}, 32'h1);
    check("rs.ovf",   {31'h0, ovf_m},   32'h0);
    check("rs.udf",   {31'h0, udf_m},   32'h0);

    // First accept after reset loads straight into the shift register.
    inen = 1'b1; in_w = 32'hC0FF_EE01;
    tick();
    inen = 1'b0;
    check("post.m_out", {28'h0, out_m}, 32'hC);
    check("post.l_out", {28'h0, out_l}, 32'h1);
    check("post.inrdy", {31'h0, inrdy_m}, 32'h1);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
